// File: rtl/xd_multi.sv
// xd_multi: multi-channel synchroniser with a per-channel stability filter
// and a one-cycle event pulse on the selected edge type.
module xd_multi #(
    parameter int CH     = 4,
    parameter int STAGES = 2,
    parameter int FILTER = 0,
    parameter int MODE   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CH-1:0] i,
    output logic [CH-1:0] lvl,
    output logic [CH-1:0] o,
    output logic          any
);

    // Counter must hold 0..FILTER; keep at least one bit when FILTER is 0.
    localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("xd_multi: STAGES must be at least 2");
        end
        if (MODE < 0 || MODE > 2) begin : g_bad_mode
            $error("xd_multi: MODE must be 0, 1 or 2");
        end
        if (CH < 1) begin : g_bad_ch
            $error("xd_multi: CH must be at least 1");
        end
        if (FILTER < 0) begin : g_bad_filter
            $error("xd_multi: FILTER must not be negative");
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [CH-1:0] sync_q [STAGES];

    logic [CH-1:0]         sync_s;
    logic [CH-1:0][CW-1:0] cnt_q;
    logic [CH-1:0][CW-1:0] cnt_d;
    logic [CH-1:0]         lvl_d;
    logic [CH-1:0]         o_d;

    assign sync_s = sync_q[STAGES-1];

    // Pulse value for a newly accepted level, according to the edge selection.
    function automatic logic edge_pulse(input logic s_new);
        logic p;
        case (MODE)
            0:       p = s_new;
            1:       p = ~s_new;
            default: p = 1'b1;
        endcase
        return p;
    endfunction

    // Synchroniser chain: first stage samples the raw inputs, later stages shift.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= i;
            for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Stability filter next state: a differing value must persist FILTER extra
    // cycles; any return to the accepted level drops the count back to zero.
    always_comb begin
        lvl_d = lvl;
        o_d   = '0;
        cnt_d = '0;
        for (int c = 0; c < CH; c++) begin
            if (sync_s[c] != lvl[c]) begin
                if (cnt_q[c] == CNT_MAX) begin
                    lvl_d[c] = sync_s[c];
                    o_d[c]   = edge_pulse(sync_s[c]);
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end
        end
    end

    // Accepted level, filter count and registered pulse outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lvl   <= '0;
            o     <= '0;
            any   <= 1'b0;
            cnt_q <= '0;
        end else begin
            lvl   <= lvl_d;
            o     <= o_d;
            any   <= |o_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xd_multi.sv
// tb_xd_multi: four xd_multi configurations driven side by side and compared
// every cycle against a sliding-window reference model of the channel rules.
module tb_xd_multi;

    localparam int NDUT = 4;
    localparam int HMAX = 8192;
    // Per-instance configuration: A defaults, B filtered rising, C falling,
    // D deeper chain with a short filter.
    localparam int STG [NDUT] = '{2, 2, 2, 3};
    localparam int FLT [NDUT] = '{0, 3, 0, 1};
    localparam int MDE [NDUT] = '{2, 0, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] iv [NDUT];

    logic [3:0] lvl_a, lvl_b, lvl_c, lvl_d;
    logic [3:0] o_a, o_b, o_c, o_d;
    logic       any_a, any_b, any_c, any_d;

    logic [3:0] lvl_w [NDUT];
    logic [3:0] o_w   [NDUT];
    logic       any_w [NDUT];

    always #5 clk = ~clk;

    xd_multi #(.CH(4), .STAGES(2), .FILTER(0), .MODE(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .i(iv[0]), .lvl(lvl_a), .o(o_a), .any(any_a));
    xd_multi #(.CH(4), .STAGES(2), .FILTER(3), .MODE(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .i(iv[1]), .lvl(lvl_b), .o(o_b), .any(any_b));
    xd_multi #(.CH(4), .STAGES(2), .FILTER(0), .MODE(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .i(iv[2]), .lvl(lvl_c), .o(o_c), .any(any_c));
    xd_multi #(.CH(4), .STAGES(3), .FILTER(1), .MODE(2)) dut_d (
        .clk_i(clk), .rst_i(rst), .i(iv[3]), .lvl(lvl_d), .o(o_d), .any(any_d));

    always_comb begin
        lvl_w[0] = lvl_a; lvl_w[1] = lvl_b; lvl_w[2] = lvl_c; lvl_w[3] = lvl_d;
        o_w[0]   = o_a;   o_w[1]   = o_b;   o_w[2]   = o_c;   o_w[3]   = o_d;
        any_w[0] = any_a; any_w[1] = any_b; any_w[2] = any_c; any_w[3] = any_d;
    end

    // Reference model state: input samples and synchronised values per edge
    // since the last reset, accepted level, expected pulse outputs.
    logic [3:0] samp [NDUT][HMAX];
    logic [3:0] shis [NDUT][HMAX];
    logic [3:0] f_m   [NDUT];
    logic [3:0] o_m   [NDUT];
    logic       any_m [NDUT];
    int         n_edge;

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        n_edge = 0;
        for (int d = 0; d < NDUT; d++) begin
            f_m[d]   = '0;
            o_m[d]   = '0;
            any_m[d] = 1'b0;
        end
    endtask

    // One clock edge of the model: the synchronised value seen at edge n is the
    // input sampled STAGES edges earlier; a channel accepts when its last
    // FILTER+1 synchronised values all differ from the accepted level.
    task automatic model_step();
        n_edge++;
        if (n_edge >= HMAX) begin
            $display("FAIL model_history n_edge=%0d limit=%0d", n_edge, HMAX);
            $fatal(1, "model history exhausted");
        end
        for (int d = 0; d < NDUT; d++) begin
            logic [3:0] s;
            logic [3:0] o_new;
            logic       acc;
            samp[d][n_edge] = iv[d];
            s = (n_edge - STG[d] >= 1) ? samp[d][n_edge - STG[d]] : 4'b0000;
            shis[d][n_edge] = s;
            o_new = '0;
            for (int ch = 0; ch < 4; ch++) begin
                acc = 1'b1;
                for (int k = 0; k <= FLT[d]; k++) begin
                    if (n_edge - k < 1) acc = 1'b0;
                    else if (shis[d][n_edge - k][ch] == f_m[d][ch]) acc = 1'b0;
                end
                if (acc) begin
                    f_m[d][ch] = s[ch];
                    o_new[ch]  = (MDE[d] == 0) ? s[ch] : (MDE[d] == 1) ? ~s[ch] : 1'b1;
                end
            end
            o_m[d]   = o_new;
            any_m[d] = |o_new;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("lvl%0d", d), lvl_w[d], f_m[d]);
            chk($sformatf("o%0d", d), o_w[d], o_m[d]);
            chk($sformatf("any%0d", d), {3'b000, any_w[d]}, {3'b000, any_m[d]});
        end
    endtask

    // Advance one edge, step the model, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic tickn(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    int pcnt;
    int tcnt [4];
    int toff [4];
    int tdone [4];
    int any_cnt;
    int dist_cnt;

    initial begin
        for (int d = 0; d < NDUT; d++) iv[d] = '0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        tickn(3);

        // Defaults: single rising change on channel 0, pulse after edge 3.
        iv[0] = 4'b0001;
        tick(); tick();
        chk("a_early_o", o_a, 4'b0000);
        tick();
        chk("a_pulse_o", o_a, 4'b0001);
        chk("a_pulse_any", {3'b000, any_a}, 4'b0001);
        chk("a_pulse_lvl", lvl_a, 4'b0001);
        tick();
        chk("a_after_o", o_a, 4'b0000);
        chk("a_after_lvl", lvl_a, 4'b0001);

        // Filter 3: a three-cycle glitch is rejected.
        iv[1][1] = 1'b1;
        tickn(3);
        iv[1][1] = 1'b0;
        pcnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (o_b[1]) pcnt++;
        end
        chk_int("b_glitch_pulses", pcnt, 0);
        chk("b_glitch_lvl", {3'b000, lvl_b[1]}, 4'b0000);

        // Filter 3: a sustained change pulses at edge 2+1+3.
        iv[1][1] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk($sformatf("b_lat_t%0d", t), {3'b000, o_b[1]}, {3'b000, (t == 6)});
        end
        tickn(4);
        chk("b_lat_lvl", {3'b000, lvl_b[1]}, 4'b0001);

        // Falling-edge mode: one pulse on the falling acceptance only.
        pcnt = 0;
        iv[2][2] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (o_c[2]) pcnt++;
        end
        chk("c_rise_lvl", {3'b000, lvl_c[2]}, 4'b0001);
        iv[2][2] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (o_c[2]) pcnt++;
        end
        chk_int("c_pulses", pcnt, 1);
        chk("c_fall_lvl", {3'b000, lvl_c[2]}, 4'b0000);

        // Asynchronous reset mid-filter, inputs held high through reset.
        iv[1] = 4'b0000;
        tickn(10);
        iv[1] = 4'b1010;
        tickn(4);
        chk("b_prerst_lvl", lvl_b, 4'b0000);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_lvl_b", lvl_b, 4'b0000);
        chk("rst_o_a", o_a, 4'b0000);
        chk("rst_lvl_a", lvl_a, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk($sformatf("b_rel_t%0d", t), o_b & 4'b1010, (t == 6) ? 4'b1010 : 4'b0000);
        end
        pcnt = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (o_b != 4'b0000) pcnt++;
        end
        chk_int("b_held_pulses", pcnt, 0);

        // Toggle stream on the defaults instance, per-channel random skew.
        for (int ch = 0; ch < 4; ch++) begin
            tcnt[ch]  = 0;
            tdone[ch] = 0;
            toff[ch]  = int'($urandom_range(0, 4));
        end
        any_cnt  = 0;
        dist_cnt = 0;
        for (int t = 0; t < 120; t++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (t >= toff[ch] && ((t - toff[ch]) % 5) == 0 && tdone[ch] < 20) begin
                    iv[0][ch] = ~iv[0][ch];
                    tdone[ch]++;
                end
            end
            tick();
            for (int ch = 0; ch < 4; ch++) if (o_a[ch]) tcnt[ch]++;
            if (any_a) any_cnt++;
            if (o_a != 4'b0000) dist_cnt++;
        end
        for (int ch = 0; ch < 4; ch++) chk_int($sformatf("tog_pulses%0d", ch), tcnt[ch], 20);
        chk_int("tog_any_cycles", any_cnt, dist_cnt);

        // Random levels on every instance against the model.
        for (int t = 0; t < 400; t++) begin
            for (int d = 0; d < NDUT; d++)
                for (int ch = 0; ch < 4; ch++)
                    if ($urandom_range(0, 5) == 0) iv[d][ch] = ~iv[d][ch];
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xd_multi.md
# xd_multi

Multi-channel single-clock synchroniser and event detector. Brings CH asynchronous level or toggle signals into the `clk_i` domain through a STAGES-deep flop chain. It optionally rejects glitches with a per-channel stability filter, then emits one-cycle pulses on the selected edge type. It is the destination-side building block for crossing many toggle-encoded events, or raw external levels such as buttons and status lines, into one domain.

## Interface
- CH, 4: number of independent channels (≥1)
- STAGES, 2: synchroniser depth in flops (≥2)
- FILTER, 0: extra consecutive cycles a new synchronised value must persist before acceptance; 0 = no filtering
- MODE, 2: pulse condition: 0 rising, 1 falling, 2 both edges (toggle decode)

- clk_i  input  1  the one clock
- rst_i  input  1  reset, asynchronous, active-high
- i  input  CH  asynchronous inputs, one bit per channel, no timing relation to clk_i
- lvl  output  CH  accepted (synchronised, filtered) level per channel, registered
- o  output  CH  one-cycle event pulse per channel, registered
- any  output  1  registered OR of the o bits

## Operation
- Per channel, fully independent:
  - sync chain s[0..STAGES-1]; s[0] samples i each clk_i edge; s = s[STAGES-1].
  - accepted level f drives lvl.
  - filter counter c, width $clog2(FILTER+1), minimum 1 bit.
- Each clock edge, per channel:
  - s == f: c <= 0, o <= 0.
  - s != f and c < FILTER: c <= c+1, o <= 0.
  - s != f and c == FILTER: f <= s, c <= 0, o <= the edge condition per MODE.
    - MODE 0: o <= s.
    - MODE 1: o <= ~s.
    - MODE 2: o <= 1.
- FILTER=0: every synchronised change is accepted on the next edge.
- A change of s back to f before acceptance clears c. The glitch is rejected: no pulse, lvl unchanged.
- any <= OR of the next-state o values, so any coincides with o.
- Reset (rst_i high, asynchronous assert):
  - All sync flops, f, c, o and any clear to 0 immediately.
  - Reset is held regardless of clock.
- Reset release:
  - Normal operation resumes on the first clk_i edge with rst_i low.
  - An input already high propagates as a 0→1 transition and yields one pulse in MODE 0/2.
- Reset mid-filter discards the pending count.
- MODE 2 with toggle sources: each source toggle produces exactly one pulse, provided toggles are spaced at least STAGES+FILTER+2 clk_i cycles apart.
  - Closer spacing may merge or lose events. This is the documented limit, not an error condition.
- Invalid parameters (STAGES<2, MODE>2, CH<1) are rejected at elaboration.

## Timing
- Edge numbering: i changes and is first sampled at edge 1.
  - s reflects it after edge STAGES.
  - f, lvl and o update at edge STAGES+1+FILTER.
- Latency, input change to pulse: STAGES+1+FILTER edges. Add ±1 cycle for metastability resolution on the first stage.
- o and any are high for exactly one cycle per accepted transition.
- A new pulse on the same channel needs at least FILTER+1 further cycles.
- Simultaneous transitions on several channels give simultaneous pulses; any is a single one-cycle pulse.
- All outputs are registered. No combinational path from i or rst_i release to any output, except the asynchronous clear.
- Sync-chain flops carry the tool's synchroniser/ASYNC_REG attribute.

## Test plan
- Defaults (CH=4, STAGES=2, FILTER=0, MODE=2); i[0] 0→1 between edges, held → o[0]=1 for one cycle after edge 3, lvl[0]=1 from then, any matches, other channels stay 0.
- FILTER=3, MODE=0; i[1] high for 3 cycles then low → no pulse, lvl[1]=0. Then i[1] high for 4+ cycles → one o[1] pulse at edge 2+1+3=6 after the change.
- MODE=1; i[2] 0→1→0 with 10 cycles between changes → exactly one pulse, on the falling acceptance, lvl[2] follows both changes.
- MODE=2 toggle stream on all 4 channels, 20 toggles each, spacing 5 cycles, randomly skewed → exactly 20 pulses per channel; any count equals the number of distinct pulse cycles.
- rst_i asserted asynchronously mid-filter (c=2, FILTER=3) → lvl, o, any are 0 immediately with no clock. Release with i high → one rising pulse after STAGES+1+FILTER edges.
- i[3] held high through reset, MODE=0 → single o[3] pulse after release, then none while i[3] stays high.
